// File: rtl/fifo_ctrl_32x1024_if.sv
// User-side port bundle of the 32x1024 FIFO controller: write/read requests,
// read-data return and the status and error flags.
interface fifo_ctrl_32x1024_if;
  logic        flush;
  logic        push;
  logic [31:0] wr_data;
  logic        pop;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [10:0] count;
  logic        overflow;
  logic        underflow;

  // Handshake: a push is taken in any cycle where push=1 and full=0, and a pop
  // where pop=1 and empty=0 (flags as registered at the start of the cycle).
  // A refused request is not retried; it only sets the sticky overflow or
  // underflow flag. Each taken pop returns rd_data with rd_valid=1 exactly one
  // cycle later, and rd_data is only meaningful while rd_valid=1.
  modport master (
    output flush, push, wr_data, pop,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, push, wr_data, pop,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_32x1024.sv
// Synchronous FIFO controller driving an external 32x1024 dual-port SRAM.
// It uses 11-bit wrap-flagged pointers and keeps count and all flags registered.
module fifo_ctrl_32x1024 #(
  parameter int AFULL_THRESH  = 1008,
  parameter int AEMPTY_THRESH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_ctrl_32x1024_if.slave   bus,
  output logic                 ram_wen,
  output logic [9:0]           ram_waddr,
  output logic [31:0]          ram_din,
  output logic                 ram_ren,
  output logic [9:0]           ram_raddr,
  input  logic [31:0]          ram_dout
);

  localparam logic [10:0] AF_LVL = 11'(AFULL_THRESH);
  localparam logic [10:0] AE_LVL = 11'(AEMPTY_THRESH);

  logic [10:0] wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  logic [10:0] count_q;
  logic        empty_q, full_q, afull_q, aempty_q;
  logic        rd_valid_q, overflow_q, underflow_q;
  logic        push_ok, pop_ok;

  // Acceptance uses the flags registered at cycle start; reset and flush
  // cycles never touch the SRAM.
  assign push_ok = rst_n && !bus.flush && bus.push && !full_q;
  assign pop_ok  = rst_n && !bus.flush && bus.pop  && !empty_q;

  assign ram_wen   = push_ok;
  assign ram_waddr = wptr[9:0];
  assign ram_din   = bus.wr_data;
  assign ram_ren   = pop_ok;
  assign ram_raddr = rptr[9:0];

  always_comb begin
    wptr_nxt  = wptr + {10'd0, push_ok};
    rptr_nxt  = rptr + {10'd0, pop_ok};
    count_nxt = wptr_nxt - rptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr        <= wptr_nxt;
      rptr        <= rptr_nxt;
      count_q     <= count_nxt;
      // Flags come from the next pointers so they always agree with count_q.
      empty_q     <= (wptr_nxt == rptr_nxt);
      full_q      <= (wptr_nxt[9:0] == rptr_nxt[9:0]) && (wptr_nxt[10] != rptr_nxt[10]);
      afull_q     <= (count_nxt >= AF_LVL);
      aempty_q    <= (count_nxt <= AE_LVL);
      rd_valid_q  <= pop_ok;
      overflow_q  <= overflow_q  | (bus.push && full_q);
      underflow_q <= underflow_q | (bus.pop  && empty_q);
    end
  end

  assign bus.rd_data      = ram_dout;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_32x1024.sv
// Bench for fifo_ctrl_32x1024: a directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a queue-based model.
module tb_fifo_ctrl_32x1024;
  localparam int AF = 1008;
  localparam int AE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_wen, ram_ren;
  logic [9:0]  ram_waddr, ram_raddr;
  logic [31:0] ram_din, ram_dout;
  logic [31:0] mem [1024];

  fifo_ctrl_32x1024_if bus ();

  fifo_ctrl_32x1024 #(.AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_din(ram_din),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  // Clock and SRAM model: write on the rising edge, read on the falling edge.
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_wen) mem[ram_waddr] <= ram_din;
  always @(negedge clk) if (ram_ren) ram_dout <= mem[ram_raddr];

  // Scoreboard / reference model state.
  logic [31:0] exp_q[$];
  int          m_wa, m_ra;
  bit          m_ov, m_uf, m_rv;
  logic [31:0] m_rd;
  bit          chk_en;
  int          n_tests, n_fail;
  logic        c_r, c_f, c_pu, c_po;
  logic [31:0] c_d;

  typedef struct {
    logic r, f, pu, po;
    logic [31:0] d;
    logic [10:0] e_cnt;
    logic e_empty, e_wen, e_ren, e_rv;
    logic [31:0] e_rd;
    logic e_uf;
  } vec_t;
  vec_t tbl [12];

  function automatic vec_t mk(input logic r, f, pu, po, input logic [31:0] d,
                              input logic [10:0] cnt, input logic emp, wen, ren, rv,
                              input logic [31:0] rd, input logic uf);
    vec_t v;
    v.r = r; v.f = f; v.pu = pu; v.po = po; v.d = d;
    v.e_cnt = cnt; v.e_empty = emp; v.e_wen = wen; v.e_ren = ren; v.e_rv = rv;
    v.e_rd = rd; v.e_uf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then settle for sampling.
  task automatic cycle_begin(input logic r, f, pu, po, input logic [31:0] d);
    @(posedge clk);
    #1;
    rst_n = r; bus.flush = f; bus.push = pu; bus.pop = po; bus.wr_data = d;
    c_r = r; c_f = f; c_pu = pu; c_po = po; c_d = d;
    #2;
  endtask

  // Compare against the model, then advance the model by this cycle's inputs.
  task automatic model_step();
    int  sz;
    bit  acc_pu, acc_po;
    sz     = exp_q.size();
    acc_pu = c_r && !c_f && c_pu && (sz < 1024);
    acc_po = c_r && !c_f && c_po && (sz > 0);
    if (chk_en) begin
      chk("count", 32'(bus.count), 32'(sz));
      chk("empty", 32'(bus.empty), 32'(sz == 0));
      chk("full", 32'(bus.full), 32'(sz == 1024));
      chk("almost_full", 32'(bus.almost_full), 32'(sz >= AF));
      chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
      chk("overflow", 32'(bus.overflow), 32'(m_ov));
      chk("underflow", 32'(bus.underflow), 32'(m_uf));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
      if (m_rv) chk("rd_data", bus.rd_data, m_rd);
      chk("ram_wen", 32'(ram_wen), 32'(acc_pu));
      chk("ram_ren", 32'(ram_ren), 32'(acc_po));
      chk("ram_waddr", 32'(ram_waddr), 32'(m_wa));
      chk("ram_raddr", 32'(ram_raddr), 32'(m_ra));
      if (acc_pu) chk("ram_din", ram_din, c_d);
    end
    if (!c_r || c_f) begin
      exp_q.delete();
      m_wa = 0; m_ra = 0; m_ov = 0; m_uf = 0; m_rv = 0;
    end else begin
      if (c_pu && !acc_pu) m_ov = 1;
      if (c_po && !acc_po) m_uf = 1;
      m_rv = acc_po;
      if (acc_po) begin
        m_rd = exp_q.pop_front();
        m_ra = (m_ra + 1) % 1024;
      end
      if (acc_pu) begin
        exp_q.push_back(c_d);
        m_wa = (m_wa + 1) % 1024;
      end
    end
  endtask

  task automatic step(input logic r, f, pu, po, input logic [31:0] d);
    cycle_begin(r, f, pu, po, d);
    model_step();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 0;
    m_wa = 0; m_ra = 0; m_ov = 0; m_uf = 0; m_rv = 0; m_rd = '0;
    rst_n = 1'b0; bus.flush = 0; bus.push = 0; bus.pop = 0; bus.wr_data = '0;

    //        r  f  pu po data   cnt emp wen ren rv rd uf
    tbl[0]  = mk(0, 0, 1, 1, 32'h99, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0, 32'h1,  0, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 0, 32'h2,  1, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 0, 32'h3,  2, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 1, 0, 32'h4,  3, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 1, 32'h0,  4, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 1, 32'h0,  3, 0, 0, 1, 1, 1, 0);
    tbl[7]  = mk(1, 0, 0, 1, 32'h0,  2, 0, 0, 1, 1, 2, 0);
    tbl[8]  = mk(1, 0, 0, 1, 32'h0,  1, 0, 0, 1, 1, 3, 0);
    tbl[9]  = mk(1, 0, 0, 0, 32'h0,  0, 1, 0, 0, 1, 4, 0);
    tbl[10] = mk(1, 0, 0, 1, 32'h0,  0, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 1);

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk_en = 1;

    // Directed vectors: reset, push 1..4, pop 4, then pop while empty.
    for (int i = 0; i < 12; i++) begin
      cycle_begin(tbl[i].r, tbl[i].f, tbl[i].pu, tbl[i].po, tbl[i].d);
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d_wen", i), 32'(ram_wen), 32'(tbl[i].e_wen));
      chk($sformatf("vec%0d_ren", i), 32'(ram_ren), 32'(tbl[i].e_ren));
      chk($sformatf("vec%0d_rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("vec%0d_rd_data", i), bus.rd_data, tbl[i].e_rd);
      chk($sformatf("vec%0d_underflow", i), 32'(bus.underflow), 32'(tbl[i].e_uf));
      model_step();
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk("underflow_sticky", 32'(bus.underflow), 32'd1);

    // Fill to 1024, then a rejected 1025th push.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) step(1, 0, 1, 0, $urandom);
    cycle_begin(1, 0, 1, 0, 32'hDEAD_BEEF);
    chk("fill_count", 32'(bus.count), 32'd1024);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_almost_full", 32'(bus.almost_full), 32'd1);
    chk("push1025_wen", 32'(ram_wen), 32'd0);
    model_step();
    step(1, 0, 0, 0, 0);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    // Push+pop while full: pop only. Then drain past empty.
    step(1, 0, 1, 1, $urandom);
    step(1, 0, 1, 0, $urandom);
    for (int i = 0; i < 1030; i++) step(1, 0, 0, 1, 0);

    // Fill 1000, then 2000 cycles of simultaneous push+pop across the wrap.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) step(1, 0, 1, 0, $urandom);
    for (int i = 0; i < 2000; i++) step(1, 0, 1, 1, $urandom);
    chk("stream_count", 32'(bus.count), 32'd1000);

    // Flush with push asserted after filling 10.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 1, 0, $urandom);
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 1, $urandom);
    cycle_begin(1, 1, 1, 0, 32'h1234_5678);
    chk("flush_wen", 32'(ram_wen), 32'd0);
    model_step();
    step(1, 0, 0, 0, 0);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);

    // Mid-stream reset with a pending pop.
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, $urandom);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_pop_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_pop_count", 32'(bus.count), 32'd0);

    // Randomized traffic: push-heavy, pop-heavy and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 700; i++) begin
        logic r, f, pu, po;
        r  = ($urandom_range(0, 255) != 0);
        f  = ($urandom_range(0, 127) == 0);
        pu = (ph == 0) ? ($urandom_range(0, 9) < 9) : (ph == 1) ? ($urandom_range(0, 9) < 2) : 1'($urandom_range(0, 1));
        po = (ph == 0) ? ($urandom_range(0, 9) < 2) : (ph == 1) ? ($urandom_range(0, 9) < 9) : 1'($urandom_range(0, 1));
        step(r, f, pu, po, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
